// File: rtl/ram_ctrl.sv
// rtl/ram_ctrl.sv - burst read/write/clear controller for a single-port synchronous RAM
// Memory-side outputs are combinational from state and handshakes; the RAM samples them at the next edge.
module ram_ctrl #(
   parameter int AW = 5,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [AW-1:0] cmd_addr,
   input  logic [AW-1:0] cmd_len,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [DW-1:0] wr_data,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [DW-1:0] rd_data,
   output logic          busy,
   output logic          mem_cen,
   output logic          mem_wen,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      RD_REQ  = 3'd2,
      RD_WAIT = 3'd3,
      RD_OUT  = 3'd4,
      CLR     = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] count_q, count_d;
   logic [DW-1:0] rd_data_q, rd_data_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         count_q   <= count_d;
         rd_data_q <= rd_data_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      count_d   = count_q;
      rd_data_d = rd_data_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  2'b00: begin
                     addr_d  = cmd_addr;
                     count_d = cmd_len;
                     state_d = RD_REQ;
                  end
                  2'b01: begin
                     addr_d  = cmd_addr;
                     count_d = cmd_len;
                     state_d = WR;
                  end
                  2'b10: begin
                     addr_d  = '0;
                     count_d = '1;
                     state_d = CLR;
                  end
                  default: ;
               endcase
            end
         end
         WR: begin
            if (wr_valid) begin
               if (count_q == '0) begin
                  state_d = IDLE;
               end else begin
                  addr_d  = addr_q + 1'b1;
                  count_d = count_q - 1'b1;
               end
            end
         end
         RD_REQ: state_d = RD_WAIT;
         // RAM output is only valid for the cycle after the request; capture it here
         RD_WAIT: begin
            rd_data_d = mem_dout;
            state_d   = RD_OUT;
         end
         RD_OUT: begin
            if (rd_ready) begin
               if (count_q == '0) begin
                  state_d = IDLE;
               end else begin
                  addr_d  = addr_q + 1'b1;
                  count_d = count_q - 1'b1;
                  state_d = RD_REQ;
               end
            end
         end
         CLR: begin
            addr_d = addr_q + 1'b1;
            if (count_q == '0) begin
               state_d = IDLE;
            end else begin
               count_d = count_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      wr_ready  = 1'b0;
      rd_valid  = 1'b0;
      mem_cen   = 1'b0;
      mem_wen   = 1'b0;
      mem_din   = '0;
      case (state_q)
         IDLE: cmd_ready = 1'b1;
         WR: begin
            wr_ready = 1'b1;
            if (wr_valid) begin
               mem_cen = 1'b1;
               mem_wen = 1'b1;
               mem_din = wr_data;
            end
         end
         RD_REQ: mem_cen = 1'b1;
         RD_OUT: rd_valid = 1'b1;
         CLR: begin
            mem_cen = 1'b1;
            mem_wen = 1'b1;
         end
         default: ;
      endcase
   end

   assign mem_addr = addr_q;
   assign rd_data  = rd_data_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ram_ctrl.sv
// tb/tb_ram_ctrl.sv - directed self-checking bench for ram_ctrl with a behavioural 32x32 RAM
module tb_ram_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [4:0]  cmd_addr;
   logic [4:0]  cmd_len;
   logic        wr_valid;
   logic        wr_ready;
   logic [31:0] wr_data;
   logic        rd_valid;
   logic        rd_ready;
   logic [31:0] rd_data;
   logic        busy;
   logic        mem_cen;
   logic        mem_wen;
   logic [4:0]  mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;

   logic [31:0] ram [32];
   logic [31:0] exp_mem [32];
   int          n_checks = 0;
   int          n_errors = 0;

   ram_ctrl #(.AW(5), .DW(32)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_data   (wr_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .busy      (busy),
      .mem_cen   (mem_cen),
      .mem_wen   (mem_wen),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout)
   );

   always #5 clk = ~clk;

   // RAM drives zero on dout unless a read was issued the cycle before
   always @(posedge clk) begin
      if (mem_cen && mem_wen) ram[mem_addr] <= mem_din;
      if (mem_cen && !mem_wen) mem_dout <= ram[mem_addr];
      else mem_dout <= '0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [4:0] addr, input logic [4:0] len);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_len   = len;
      #1;
      check("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic write_burst(input logic [4:0] addr, input logic [4:0] len,
                              input logic [31:0] base, input logic [31:0] step);
      logic [4:0]  a;
      logic [31:0] d;
      issue(2'b01, addr, len);
      for (int i = 0; i <= int'(len); i++) begin
         a = addr + 5'(i);
         d = base + 32'(i) * step;
         wr_valid = 1'b1;
         wr_data  = d;
         #1;
         check("wr_ready", {31'b0, wr_ready}, 32'd1);
         check("wr_cen_wen", {30'b0, mem_cen, mem_wen}, 32'd3);
         check("wr_addr", {27'b0, mem_addr}, {27'b0, a});
         check("wr_din", mem_din, d);
         exp_mem[a] = d;
         @(negedge clk);
      end
      wr_valid = 1'b0;
      #1;
      check("wr_busy_done", {31'b0, busy}, 32'd0);
   endtask

   task automatic read_burst(input logic [4:0] addr, input logic [4:0] len);
      logic [4:0] a;
      issue(2'b00, addr, len);
      for (int i = 0; i <= int'(len); i++) begin
         a = addr + 5'(i);
         check("rd_req", {26'b0, mem_cen, mem_wen, mem_addr}, {26'b0, 2'b10, a});
         @(negedge clk);
         check("rd_wait", {30'b0, mem_cen, rd_valid}, 32'd0);
         @(negedge clk);
         check("rd_valid", {31'b0, rd_valid}, 32'd1);
         check("rd_data", rd_data, exp_mem[a]);
         rd_ready = 1'b1;
         @(negedge clk);
         rd_ready = 1'b0;
      end
      #1;
      check("rd_busy_done", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      int cyc;
      int bad;
      for (int i = 0; i < 32; i++) begin
         ram[i]     = 32'hDEAD_0000 + 32'(i);
         exp_mem[i] = 32'hDEAD_0000 + 32'(i);
      end
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'b11;
      cmd_addr  = '0;
      cmd_len   = '0;
      wr_valid  = 1'b0;
      wr_data   = '0;
      rd_ready  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_ready_busy", {30'b0, cmd_ready, busy}, 32'd2);
      check("rst_valids", {29'b0, rd_valid, wr_ready, mem_cen}, 32'd0);
      check("rst_wen_din", {31'b0, mem_wen} | mem_din, 32'd0);
      check("rst_rd_data", rd_data, 32'd0);
      check("rst_addr", {27'b0, mem_addr}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      write_burst(5'd2, 5'd3, 32'hA0, 32'h1);
      check("ram2", ram[2], 32'hA0);
      check("ram5", ram[5], 32'hA3);
      read_burst(5'd2, 5'd3);

      write_burst(5'd30, 5'd2, 32'h11, 32'h11);
      check("ram30", ram[30], 32'h11);
      check("ram31", ram[31], 32'h22);
      check("ram0", ram[0], 32'h33);
      read_burst(5'd30, 5'd2);

      issue(2'b00, 5'd3, 5'd0);
      check("bp_req", {26'b0, mem_cen, mem_wen, mem_addr}, {26'b0, 2'b10, 5'd3});
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         check("bp_hold", {30'b0, rd_valid, mem_cen}, 32'd2);
         check("bp_data", rd_data, 32'hA1);
         @(negedge clk);
      end
      rd_ready = 1'b1;
      #1;
      check("bp_valid_hs", {31'b0, rd_valid}, 32'd1);
      @(negedge clk);
      rd_ready = 1'b0;
      #1;
      check("bp_done", {30'b0, busy, rd_valid}, 32'd0);

      issue(2'b01, 5'd10, 5'd1);
      wr_valid = 1'b1;
      wr_data  = 32'h77;
      #1;
      check("st_hs1", {26'b0, mem_cen, mem_wen, mem_addr}, {26'b0, 2'b11, 5'd10});
      @(negedge clk);
      wr_valid  = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = 2'b11;
      for (int k = 0; k < 2; k++) begin
         #1;
         check("st_idle", {25'b0, mem_cen, mem_wen, wr_ready, mem_addr}, {25'b0, 3'b001, 5'd11});
         check("st_cmd_blocked", {31'b0, cmd_ready}, 32'd0);
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      wr_valid  = 1'b1;
      wr_data   = 32'h88;
      #1;
      check("st_hs2", {26'b0, mem_cen, mem_wen, mem_addr}, {26'b0, 2'b11, 5'd11});
      @(negedge clk);
      wr_valid = 1'b0;
      #1;
      check("st_done", {31'b0, busy}, 32'd0);
      check("ram10", ram[10], 32'h77);
      check("ram11", ram[11], 32'h88);

      issue(2'b10, 5'd7, 5'd3);
      cyc = 0;
      bad = 0;
      for (int k = 0; k < 40 && busy; k++) begin
         if (!(mem_cen && mem_wen && mem_din == 32'd0 && mem_addr == 5'(k))) bad++;
         cyc++;
         @(negedge clk);
      end
      check("clr_cycles", 32'(cyc), 32'd32);
      check("clr_bad", 32'(bad), 32'd0);
      for (int i = 0; i < 32; i++) exp_mem[i] = 32'd0;
      check("clr_ram5", ram[5], 32'd0);
      read_burst(5'd0, 5'd31);

      issue(2'b11, 5'd4, 5'd4);
      #1;
      check("noop", {29'b0, busy, mem_cen, cmd_ready}, 32'd1);
      @(negedge clk);
      check("noop_after", {30'b0, busy, mem_cen}, 32'd0);

      issue(2'b01, 5'd20, 5'd3);
      wr_valid = 1'b1;
      wr_data  = 32'h51;
      @(negedge clk);
      wr_data  = 32'h52;
      @(negedge clk);
      wr_data  = 32'h53;
      #1;
      check("rb_third", {26'b0, mem_cen, mem_wen, mem_addr}, {26'b0, 2'b11, 5'd22});
      reset_n = 1'b0;
      #1;
      check("rb_ready_busy", {30'b0, cmd_ready, busy}, 32'd2);
      check("rb_outs", {28'b0, wr_ready, rd_valid, mem_cen, mem_wen}, 32'd0);
      check("rb_din", mem_din, 32'd0);
      wr_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check("rb_ram20", ram[20], 32'h51);
      check("rb_ram21", ram[21], 32'h52);
      check("rb_ram22", ram[22], 32'h0);
      exp_mem[20] = 32'h51;
      exp_mem[21] = 32'h52;
      @(negedge clk);
      write_burst(5'd22, 5'd0, 32'h99, 32'h0);
      read_burst(5'd20, 5'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Initiator-side controller that drives the 32x32 single-port synchronous RAM (cen/wen/addr/din in, registered dout out, 1-cycle read latency).
- Accepts burst commands from a host over a valid/ready command channel.
- Streams write data in and read data out over valid/ready channels.
- Provides a clear-all operation, because the RAM has no reset of its own.

Parameters:
- AW, 5, RAM address width; depth is 2**AW.
- DW, 32, RAM data width.

Ports:
- clk  in  1  rising-edge clock, shared with the RAM
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  2  00 read burst, 01 write burst, 10 clear all, 11 no-op
- cmd_addr  in  AW  burst start address
- cmd_len  in  AW  burst length minus 1 (1..32 words)
- wr_valid  in  1  write data present
- wr_ready  out  1  write data accepted
- wr_data  in  DW  write word
- rd_valid  out  1  read word available
- rd_ready  in  1  host accepts read word
- rd_data  out  DW  read word
- busy  out  1  high whenever state != IDLE
- mem_cen  out  1  RAM chip enable
- mem_wen  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_din  out  DW  RAM write data
- mem_dout  in  DW  RAM registered read data

Behaviour:
- Registers: state, cur_addr, count, rd_data.
- Memory-side outputs are combinational from state and the handshakes. The RAM samples them at the next posedge.
- Reset (async, reset_n=0):
  - state=IDLE; cur_addr=0; count=0; rd_data=0.
  - Therefore cmd_ready=1, busy=0, rd_valid=0, wr_ready=0, mem_cen=0, mem_wen=0, mem_din=0.
  - Reset mid-burst aborts the burst immediately. RAM contents are not altered beyond writes already clocked.
- Default outputs: mem_addr=cur_addr, mem_din=0, mem_cen=0, mem_wen=0.
- IDLE:
  - cmd_ready=1. A command is accepted when cmd_valid=1.
  - op 00: cur_addr=cmd_addr, count=cmd_len, next state RD_REQ.
  - op 01: cur_addr=cmd_addr, count=cmd_len, next state WR.
  - op 10: cur_addr=0, count=2**AW-1, next state CLR; cmd_addr and cmd_len are ignored.
  - op 11: accepted, no effect, stays IDLE.
- WR:
  - wr_ready=1.
  - When wr_valid=1: mem_cen=1, mem_wen=1, mem_din=wr_data, in the same cycle as the handshake.
  - On that handshake: if count==0, go to IDLE; else cur_addr+=1 (mod 2**AW), count-=1.
  - wr_valid=0 stalls with mem_cen=0.
- RD_REQ: mem_cen=1, mem_wen=0; next state RD_WAIT.
- RD_WAIT:
  - mem_cen=0. mem_dout holds the requested word.
  - rd_data<=mem_dout at the closing edge; next state RD_OUT.
  - The RAM zeroing dout at that same edge does not affect the capture.
- RD_OUT:
  - rd_valid=1; rd_data is held stable until accepted.
  - On rd_ready=1: if count==0, go to IDLE; else cur_addr+=1 (wrap), count-=1, next state RD_REQ.
  - Minimum throughput is 3 cycles per read word.
- CLR:
  - mem_cen=1, mem_wen=1, mem_din=0 every cycle; cur_addr increments.
  - After the address 2**AW-1 write, go to IDLE. Exactly 32 cycles.
- Other handshake rules:
  - cmd_ready=0 outside IDLE; commands presented while busy are not consumed.
  - wr_ready=0 outside WR; rd_valid=0 outside RD_OUT.
- Address wrap: a burst crossing 31 continues at 0. It never faults.
- Length 32 starting at any address touches each word exactly once.

Test Plan:
- Write burst op=01, addr=2, len=3, data 0xA0..0xA3 -> RAM words 2..5 = 0xA0..0xA3. Then read burst addr=2, len=3 -> rd_data sequence 0xA0,0xA1,0xA2,0xA3; busy falls after the 4th rd handshake.
- Wrap: write addr=30, len=2, data 0x11,0x22,0x33 -> mem[30]=0x11, mem[31]=0x22, mem[0]=0x33. A read of the same range returns the same words in order.
- Backpressure: read of 1 word with rd_ready held low 5 cycles -> rd_valid=1 and rd_data constant throughout; no further mem_cen pulses; completes on the rd_ready handshake.
- Write stall: wr_valid toggled 1,0,0,1 -> mem_cen/mem_wen asserted only in handshake cycles; cur_addr advances only then.
- Clear after filling: op=10 -> busy exactly 32 cycles with mem_cen=mem_wen=1, mem_din=0. A following 32-word read returns all 0x00000000. op=11 -> cmd accepted, busy stays 0, no mem_cen.
- Reset mid-burst: assert reset_n=0 during the 3rd word of a write burst -> outputs immediately take reset values; words 0..1 of the burst persist; the next command after release runs normally.
